// File: rtl/game_pkg.sv
// Shared encodings for the typing-game controller:
// FSM states, display digit codes and a 3-digit decimal splitter.
package game_pkg;

    typedef enum logic [2:0] {
        S_SELECT    = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_INGAME    = 3'd2,
        S_PAUSE     = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic [3:0] DIG_ZERO  = 4'd0;
    localparam logic [3:0] DIG_TIME  = 4'd10;
    localparam logic [3:0] DIG_WORD  = 4'd11;
    localparam logic [3:0] DIG_BLANK = 4'd12;
    localparam logic [3:0] DIG_PAUSE = 4'd13;

    localparam int TICKS_PER_SEC = 100;

    // {hundreds, tens, units} of a value up to 999
    function automatic logic [11:0] bcd3(input logic [9:0] n);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = 4'(n % 10'd10);
        d1 = 4'((n / 10'd10) % 10'd10);
        d2 = 4'((n / 10'd100) % 10'd10);
        return {d2, d1, d0};
    endfunction

endpackage

// File: rtl/game_ctrl_p_tick_gen.sv
// Free-running strobe generator: one-cycle tick every DIV clocks.
module tick_gen #(
    parameter int DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/game_ctrl_p.sv
// Game flow controller: preset selection, countdown, timed play,
// pause and finish, plus the four-digit display encoding.
module game_ctrl_p
    import game_pkg::*;
#(
    parameter int TICK_DIV   = 1000000,
    parameter int CD_TICKS   = 300,
    parameter int TIME_STEP  = 15,
    parameter int TIME_STEPS = 6,
    parameter int NUM_STEP   = 25,
    parameter int NUM_STEPS  = 4,
    parameter int VAL_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             select_up,
    input  logic             select_down,
    input  logic             pause,
    input  logic             mode,
    input  logic             finish,
    output logic             Mode,
    output logic [2:0]       state,
    output logic [VAL_W-1:0] value,
    output logic [VAL_W-1:0] remain,
    output logic             timeout,
    output logic [15:0]      nums
);

    localparam int CD_W = 16;
    localparam logic [VAL_W-1:0] T_STEP = VAL_W'(TIME_STEP);
    localparam logic [VAL_W-1:0] T_MAX  = VAL_W'(TIME_STEP * TIME_STEPS);
    localparam logic [VAL_W-1:0] N_STEP = VAL_W'(NUM_STEP);
    localparam logic [VAL_W-1:0] N_MAX  = VAL_W'(NUM_STEP * NUM_STEPS);
    localparam logic [CD_W-1:0]  CD_INIT = CD_W'(CD_TICKS);
    localparam logic [6:0]       SUB_LAST = 7'(TICKS_PER_SEC - 1);

    logic tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic [3:0] btn;
    logic [3:0] btn_q;
    logic [3:0] edges;
    logic       armed;
    logic       start_e;
    logic       up_e;
    logic       dn_e;
    logic       pause_e;

    // armed masks the first cycle so a level held through reset is not an edge
    assign btn   = {start, select_up, select_down, pause};
    assign edges = btn & ~btn_q & {4{armed}};
    assign {start_e, up_e, dn_e, pause_e} = edges;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= '0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn;
            armed <= 1'b1;
        end
    end

    state_t           st;
    state_t           st_nx;
    logic             mode_q;
    logic [VAL_W-1:0] num;
    logic [VAL_W-1:0] tim;
    logic [VAL_W-1:0] num_nx;
    logic [VAL_W-1:0] tim_nx;
    logic [VAL_W-1:0] rem;
    logic [CD_W-1:0]  cd;
    logic [6:0]       sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= S_SELECT;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            S_SELECT:    if (start_e) st_nx = S_COUNTDOWN;
            S_COUNTDOWN: if (tick && cd == '0) st_nx = S_INGAME;
            S_INGAME: begin
                if (finish || timeout)
                    st_nx = S_FINISH;
                else if (pause_e)
                    st_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (start_e)
                    st_nx = S_SELECT;
                else if (pause_e)
                    st_nx = S_INGAME;
            end
            S_FINISH:    if (start_e) st_nx = S_SELECT;
            default:     st_nx = S_SELECT;
        endcase
    end

    always_comb begin
        num_nx = num;
        tim_nx = tim;
        unique case (1'b1)
            up_e && !dn_e: begin
                if (mode_q)
                    num_nx = (num >= N_MAX) ? N_STEP : num + N_STEP;
                else
                    tim_nx = (tim >= T_MAX) ? T_STEP : tim + T_STEP;
            end
            dn_e && !up_e: begin
                if (mode_q)
                    num_nx = (num <= N_STEP) ? N_MAX : num - N_STEP;
                else
                    tim_nx = (tim <= T_STEP) ? T_MAX : tim - T_STEP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= 1'b0;
            num     <= N_STEP;
            tim     <= T_STEP;
            rem     <= '0;
            cd      <= CD_INIT;
            sub     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (st)
                S_SELECT: begin
                    mode_q <= mode;
                    num    <= num_nx;
                    tim    <= tim_nx;
                    if (start_e) begin
                        rem <= tim;
                        cd  <= CD_INIT;
                        sub <= '0;
                    end
                end
                S_COUNTDOWN: begin
                    if (tick && cd != '0)
                        cd <= cd - CD_W'(1);
                end
                S_INGAME: begin
                    // one remain step per TICKS_PER_SEC ticks, time mode only
                    if (tick && !mode_q) begin
                        if (sub == SUB_LAST) begin
                            sub <= '0;
                            if (rem != '0) begin
                                rem     <= rem - VAL_W'(1);
                                timeout <= (rem == VAL_W'(1));
                            end
                        end else begin
                            sub <= sub + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Mode   = mode_q;
    assign state  = st;
    assign value  = mode_q ? num : tim;
    assign remain = rem;

    logic [9:0] disp;
    logic [3:0] d3;
    logic       blank;

    always_comb begin
        disp  = '0;
        d3    = DIG_ZERO;
        blank = 1'b0;
        unique case (st)
            S_SELECT: begin
                disp = 10'(value);
                d3   = mode_q ? DIG_WORD : DIG_TIME;
            end
            S_COUNTDOWN: disp = 10'(cd / CD_W'(TICKS_PER_SEC));
            S_INGAME:    disp = 10'(mode_q ? num : rem);
            S_PAUSE: begin
                disp = 10'(mode_q ? num : rem);
                d3   = DIG_PAUSE;
            end
            default:     blank = 1'b1;
        endcase
        nums = blank ? {4{DIG_BLANK}} : {d3, bcd3(disp)};
    end

endmodule

// File: tb/tb_game_ctrl_p.sv
// Randomized and scenario bench for game_ctrl_p against a
// preset-index and tick-count reference model.
module tb_game_ctrl_p;

    localparam int TD = 4;
    localparam int CDT = 3;
    localparam int TS = 15;
    localparam int TN = 6;
    localparam int NS = 25;
    localparam int NN = 4;
    localparam int VW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic select_up = 1'b0;
    logic select_down = 1'b0;
    logic pause = 1'b0;
    logic mode = 1'b0;
    logic finish = 1'b0;
    logic Mode;
    logic [2:0] state;
    logic [VW-1:0] value;
    logic [VW-1:0] remain;
    logic timeout;
    logic [15:0] nums;

    int total = 0;
    int bad = 0;
    int t_idx = 1;
    int n_idx = 1;
    int gi = 0;
    int gticks = 0;

    always #5 clk = ~clk;

    game_ctrl_p #(
        .TICK_DIV(TD), .CD_TICKS(CDT), .TIME_STEP(TS), .TIME_STEPS(TN),
        .NUM_STEP(NS), .NUM_STEPS(NN), .VAL_W(VW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .select_up(select_up),
        .select_down(select_down), .pause(pause), .mode(mode),
        .finish(finish), .Mode(Mode), .state(state), .value(value),
        .remain(remain), .timeout(timeout), .nums(nums)
    );

    function automatic logic [15:0] exp_nums(input int d3, input int n);
        return 16'(d3 * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + n % 10);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit u, input bit d, input bit s, input bit p, input int hold);
        if (u) select_up = 1'b1;
        if (d) select_down = 1'b1;
        if (s) start = 1'b1;
        if (p) pause = 1'b1;
        cyc(hold);
        if (u) select_up = 1'b0;
        if (d) select_down = 1'b0;
        if (s) start = 1'b0;
        if (p) pause = 1'b0;
        cyc(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {start, select_up, select_down, pause, finish, mode} = '0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        t_idx = 1;
        n_idx = 1;
    endtask

    // leaves the caller at the first negedge showing INGAME
    task automatic wait_ingame(output int n);
        n = 0;
        while (state !== 3'd2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        gi = 0;
        gticks = 0;
    endtask

    // advance one cycle, counting ticks the play timer consumes
    task automatic step();
        if (state == 3'd2 && (gi % TD) == TD - 1) gticks++;
        gi++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got %0d want 0", state); end
        total++; if (Mode !== 1'b0) begin bad++; $display("FAIL rst_mode got %0d want 0", Mode); end
        total++; if (value !== VW'(TS)) begin bad++; $display("FAIL rst_value got %0d want %0d", value, TS); end
        total++; if (remain !== '0) begin bad++; $display("FAIL rst_remain got %0d want 0", remain); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got %0d want 0", timeout); end
        total++; if (nums !== exp_nums(10, TS)) begin bad++; $display("FAIL rst_nums got %h want %h", nums, exp_nums(10, TS)); end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_presets();
        mode = 1'b0;
        cyc(2);
        for (int i = 0; i < TN; i++) begin
            press(1, 0, 0, 0, 1);
            t_idx = t_idx % TN + 1;
            total++;
            if (value !== VW'(t_idx * TS)) begin
                bad++; $display("FAIL up_seq%0d got %0d want %0d", i, value, t_idx * TS);
            end
        end
        mode = 1'b1;
        cyc(2);
        press(0, 1, 0, 0, 3);
        n_idx = (n_idx + NN - 2) % NN + 1;
        total++; if (value !== VW'(n_idx * NS)) begin bad++; $display("FAIL word_down got %0d want %0d", value, n_idx * NS); end
        total++; if (nums !== exp_nums(11, n_idx * NS)) begin bad++; $display("FAIL word_nums got %h want %h", nums, exp_nums(11, n_idx * NS)); end
    endtask

    task automatic test_random_presets();
        int m, op, ev;
        for (int k = 0; k < 40; k++) begin
            m = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            mode = m[0];
            cyc(2);
            press(op == 0 || op == 2, op == 1 || op == 2, 0, 0, int'($urandom_range(1, 4)));
            if (op == 0) begin
                if (m == 1) n_idx = n_idx % NN + 1; else t_idx = t_idx % TN + 1;
            end else if (op == 1) begin
                if (m == 1) n_idx = (n_idx + NN - 2) % NN + 1; else t_idx = (t_idx + TN - 2) % TN + 1;
            end
            ev = (m == 1) ? n_idx * NS : t_idx * TS;
            total++;
            if (value !== VW'(ev) || Mode !== m[0]) begin
                bad++; $display("FAIL rnd%0d op%0d value/mode got %0d/%0d want %0d/%0d", k, op, value, Mode, ev, m);
            end
            total++;
            if (nums !== exp_nums(m == 1 ? 11 : 10, ev)) begin
                bad++; $display("FAIL rnd%0d nums got %h want %h", k, nums, exp_nums(m == 1 ? 11 : 10, ev));
            end
        end
    endtask

    task automatic test_timeout();
        int n, pulses, at;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL cd_enter got %0d want 1", state); end
        total++; if (nums !== exp_nums(0, 0)) begin bad++; $display("FAIL cd_nums got %h want %h", nums, exp_nums(0, 0)); end
        n = 0;
        while (state === 3'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < 3 * TD + 1 || n > 4 * TD) begin
            bad++; $display("FAIL cd_len got %0d cycles want %0d..%0d", n, 3 * TD + 1, 4 * TD);
        end
        total++; if (state !== 3'd2 || remain !== VW'(TS)) begin bad++; $display("FAIL ingame_entry state/remain got %0d/%0d want 2/%0d", state, remain, TS); end
        total++; if (nums !== exp_nums(0, TS)) begin bad++; $display("FAIL ingame_nums got %h want %h", nums, exp_nums(0, TS)); end
        pulses = 0;
        at = -1;
        for (int i = 0; i < TS * 100 * TD + 100; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                pulses++;
                at = i + 1;
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL timeout_pulses got %0d want 1", pulses); end
        total++;
        if (at < TS * 100 * TD - TD || at > TS * 100 * TD + TD) begin
            bad++; $display("FAIL timeout_time got %0d want about %0d", at, TS * 100 * TD);
        end
        total++; if (state !== 3'd4 || remain !== '0) begin bad++; $display("FAIL finish_state got %0d/%0d want 4/0", state, remain); end
        total++; if (nums !== 16'hCCCC) begin bad++; $display("FAIL finish_nums got %h want cccc", nums); end
    endtask

    task automatic test_pause();
        int n, trans, er;
        logic [2:0] prev;
        do_reset();
        press(0, 0, 1, 0, 1);
        wait_ingame(n);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL p_ingame got %0d want 2", state); end
        repeat (500) step();
        er = TS - gticks / 100;
        total++; if (remain !== VW'(er)) begin bad++; $display("FAIL p_run got %0d want %0d", remain, er); end
        pause = 1'b1;
        trans = 0;
        for (int i = 0; i < 50; i++) begin
            prev = state;
            step();
            if (prev == 3'd2 && state == 3'd3) trans++;
        end
        pause = 1'b0;
        er = TS - gticks / 100;
        total++; if (trans != 1 || state !== 3'd3) begin bad++; $display("FAIL p_enter trans/state got %0d/%0d want 1/3", trans, state); end
        total++; if (nums !== exp_nums(13, er)) begin bad++; $display("FAIL p_nums got %h want %h", nums, exp_nums(13, er)); end
        repeat (1000) step();
        total++; if (remain !== VW'(er) || state !== 3'd3) begin bad++; $display("FAIL p_frozen got %0d/%0d want %0d/3", remain, state, er); end
        pause = 1'b1;
        step();
        pause = 1'b0;
        step();
        step();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL p_resume got %0d want 2", state); end
        repeat (900) step();
        er = TS - gticks / 100;
        total++; if (remain !== VW'(er)) begin bad++; $display("FAIL p_after got %0d want %0d", remain, er); end
        total++; if (nums !== exp_nums(0, er)) begin bad++; $display("FAIL p_after_nums got %h want %h", nums, exp_nums(0, er)); end
    endtask

    task automatic test_finish_vs_pause();
        int n;
        do_reset();
        mode = 1'b1;
        cyc(2);
        press(0, 0, 1, 0, 1);
        wait_ingame(n);
        press(1, 0, 0, 0, 2);
        cyc(500);
        total++; if (value !== VW'(NS)) begin bad++; $display("FAIL fp_preset_locked got %0d want %0d", value, NS); end
        total++; if (remain !== VW'(TS)) begin bad++; $display("FAIL fp_word_hold got %0d want %0d", remain, TS); end
        total++; if (nums !== exp_nums(0, NS)) begin bad++; $display("FAIL fp_nums got %h want %h", nums, exp_nums(0, NS)); end
        finish = 1'b1;
        pause = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        pause = 1'b0;
        cyc(2);
        total++; if (state !== 3'd4) begin bad++; $display("FAIL fp_state got %0d want 4", state); end
        press(0, 0, 1, 0, 1);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL fp_back got %0d want 0", state); end
    endtask

    task automatic test_reset_in_pause();
        int n, moved;
        do_reset();
        mode = 1'b1;
        cyc(2);
        press(0, 0, 1, 0, 1);
        wait_ingame(n);
        press(0, 0, 0, 1, 1);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL rp_pause got %0d want 3", state); end
        start = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || Mode !== 1'b0 || value !== VW'(TS)) begin
            bad++; $display("FAIL rp_reset state/Mode/value got %0d/%0d/%0d want 0/0/%0d", state, Mode, value, TS);
        end
        mode = 1'b0;
        cyc(3);
        rst = 1'b0;
        moved = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state !== 3'd0) moved++;
        end
        total++; if (moved != 0) begin bad++; $display("FAIL rp_held_start got %0d non-select cycles want 0", moved); end
        start = 1'b0;
        cyc(2);
        press(0, 0, 1, 0, 1);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL rp_repress got %0d want 1", state); end
    endtask

    initial begin
        test_reset();
        test_presets();
        test_random_presets();
        test_timeout();
        test_pause();
        test_finish_vs_pause();
        test_reset_in_pause();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl_p.md
GAME_CTRL_P -- requirements
Module: game_ctrl_p

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, meaning clk cycles per 10 ms tick.
REQ-002 SHALL have parameter CD_TICKS, default 300, meaning countdown length in ticks.
REQ-003 SHALL have parameter TIME_STEP, default 15, meaning time-mode preset increment in seconds.
REQ-004 SHALL have parameter TIME_STEPS, default 6, meaning number of time presets.
REQ-005 SHALL have parameter NUM_STEP, default 25, meaning word-mode preset increment.
REQ-006 SHALL have parameter NUM_STEPS, default 4, meaning number of word presets.
REQ-007 SHALL have parameter VAL_W, default 7, meaning preset and value width; all presets SHALL be at most 999 and SHALL fit VAL_W.
REQ-008 clk  input  1  system clock; single clock domain.
REQ-009 rst  input  1  reset; asynchronous and active-high.
REQ-010 start  input  1  level from button C.
REQ-011 select_up / select_down  input  1 each  preset step levels.
REQ-012 pause  input  1  pause toggle level.
REQ-013 mode  input  1  0 = time mode, 1 = word mode.
REQ-014 finish  input  1  target reached, from the typing engine.
REQ-015 Mode  output  1  latched mode.
REQ-016 state  output  3  FSM state.
REQ-017 value  output  VAL_W  active preset (Num if Mode, else Time).
REQ-018 remain  output  VAL_W  seconds left in time mode.
REQ-019 timeout  output  1  one-cycle pulse when remain reaches 0.
REQ-020 nums  output  16  four 4-bit display digit codes.

Function
REQ-021 start, select_up, select_down and pause SHALL be rising-edge detected internally; each held level SHALL act exactly once.
REQ-022 A tick strobe SHALL assert for one clk cycle every TICK_DIV cycles, free-running from reset.
REQ-023 States SHALL be: SELECT=0, COUNTDOWN=1, INGAME=2, PAUSE=3, FINISH=4.
REQ-024 SELECT SHALL go to COUNTDOWN on a start edge.
REQ-025 COUNTDOWN SHALL decrement the countdown counter on each tick and SHALL go to INGAME in the cycle after the counter reads 0.
REQ-026 INGAME SHALL go to FINISH on finish=1 or on timeout, and SHALL go to PAUSE on a pause edge; finish SHALL win over pause when both occur in the same cycle.
REQ-027 PAUSE SHALL return to INGAME on a pause edge, SHALL abort to SELECT on a start edge, and SHALL freeze all timers.
REQ-028 FINISH SHALL go to SELECT on a start edge.
REQ-029 Mode SHALL track mode only in SELECT and SHALL hold it in all other states.
REQ-030 In SELECT, a select_up edge SHALL step the preset of the current mode up by its STEP, wrapping from max (STEP*STEPS) to STEP.
REQ-031 In SELECT, a select_down edge SHALL step that preset down, wrapping from STEP to max.
REQ-032 Simultaneous up and down edges SHALL leave the preset unchanged.
REQ-033 Preset edges outside SELECT SHALL be ignored.
REQ-034 On entry to COUNTDOWN, remain SHALL load Time and the countdown counter SHALL load CD_TICKS.
REQ-035 In INGAME with Mode=0, remain SHALL decrement once every 100 ticks; at 1 to 0 it SHALL pulse timeout for one cycle.
REQ-036 In INGAME with Mode=1, remain SHALL hold.
REQ-037 nums SHALL be {d3,d2,d1,d0}, with d0 units, d1 tens and d2 hundreds of the displayed number.
REQ-038 In SELECT, nums SHALL show value, with d3=10 (time mode) or d3=11 (word mode).
REQ-039 In COUNTDOWN, nums SHALL show countdown seconds (counter/100) with d3=0.
REQ-040 In INGAME, nums SHALL show remain (Mode=0) or Num (Mode=1), with d3=0.
REQ-041 In PAUSE, nums SHALL show the INGAME display with d3=13.
REQ-042 In FINISH, all four digits SHALL be 12 (blank).
REQ-043 Arithmetic SHALL be unsigned; decrements SHALL saturate at 0.

Reset
REQ-044 While rst=1, the block SHALL hold: state=SELECT, Mode=0, Num=NUM_STEP, Time=TIME_STEP, remain=0, countdown counter=CD_TICKS, tick divider=0, edge history=0, timeout=0.
REQ-045 Reset asserted mid-game SHALL return the block to SELECT within the same cycle and SHALL discard the pause status.
REQ-046 A button held through reset release SHALL NOT produce an edge.

Structure
REQ-047 A shared package game_pkg SHALL hold the state encoding constants and the display codes DIG_TIME=10, DIG_WORD=11, DIG_BLANK=12, DIG_PAUSE=13.
REQ-048 Tick generation SHALL be one sub-module, tick_gen (parameter DIV; ports clk, rst, tick).
REQ-049 Edge detection and the FSM SHALL be implemented inside game_ctrl_p.

Verification (bench parameters: TICK_DIV=4, CD_TICKS=3, TIME_STEP=15, TIME_STEPS=6)
REQ-050 With mode=0, press select_up 6 times -> value sequence 30,45,60,75,90,15; with mode=1, press select_down once -> value=100 and nums d3=11.
REQ-051 Start with Time=15 -> COUNTDOWN lasts 4 ticks, then INGAME with remain=15; after 1500 ticks, timeout pulses once and state=FINISH with nums=0xCCCC.
REQ-052 Pause held 50 cycles in INGAME -> exactly one transition to PAUSE and d3=13; remain frozen; second pause edge -> INGAME and decrements resume.
REQ-053 finish and pause asserted in the same cycle during INGAME -> state=FINISH.
REQ-054 Assert rst during PAUSE with start held high -> SELECT, Time=15, Mode=0; no COUNTDOWN until start is released and pressed again.
